// File: rtl/conv_core.sv
`default_nettype none
//------------------------------------------------------------------------------
// conv_core : streaming 3x3 Gaussian smoothing ([1 2 1;2 4 2;1 2 1] / 16) over
//             raster-order pixels, two internal line buffers, 2-edge latency.
// Revision  : 1.0
//------------------------------------------------------------------------------
module conv_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_WIDTH   = 5,
  parameter int IMG_HEIGHT  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] conv_out,
  output logic                  valid_out
);

  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int RW    = $clog2(IMG_HEIGHT);
  localparam int ACC_W = DATA_WIDTH + 4;

  generate
    if (KERNEL_SIZE != 3) begin : g_bad_kernel
      $error("conv_core: only KERNEL_SIZE = 3 is supported");
    end
    if ((IMG_WIDTH < 3) || (IMG_HEIGHT < 3)) begin : g_bad_dims
      $error("conv_core: IMG_WIDTH and IMG_HEIGHT must be >= 3");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] r_lb0 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_lb1 [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_win [3][3];
  logic [CW-1:0]         r_col;
  logic [RW-1:0]         r_row;
  logic                  r_win_vld;

  logic [DATA_WIDTH-1:0] w_tap0;
  logic [DATA_WIDTH-1:0] w_tap1;
  logic                  w_eol;
  logic                  w_eof;
  logic                  w_in_window;
  logic [ACC_W-1:0]      w_sum;

  assign w_tap0      = r_lb0[IMG_WIDTH-1];
  assign w_tap1      = r_lb1[IMG_WIDTH-1];
  assign w_eol       = (r_col == CW'(IMG_WIDTH - 1));
  assign w_eof       = (r_row == RW'(IMG_HEIGHT - 1));
  assign w_in_window = (r_row >= RW'(2)) && (r_col >= CW'(2));

  // Line buffers are never reset: row gating keeps stale taps out of any valid window.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      r_lb0[0] <= pixel_in;
      r_lb1[0] <= w_tap0;
      for (int i = 1; i < IMG_WIDTH; i++) begin
        r_lb0[i] <= r_lb0[i-1];
        r_lb1[i] <= r_lb1[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_win_vld <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      r_win_vld <= valid_in && w_in_window;
      if (valid_in) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_tap1;
        r_win[1][2] <= w_tap0;
        r_win[2][2] <= pixel_in;
        if (w_eol) begin
          r_col <= '0;
          r_row <= w_eof ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

  assign w_sum = ACC_W'(r_win[0][0])        + ACC_W'(r_win[0][2])
               + ACC_W'(r_win[2][0])        + ACC_W'(r_win[2][2])
               + (ACC_W'(r_win[0][1]) << 1) + (ACC_W'(r_win[1][0]) << 1)
               + (ACC_W'(r_win[1][2]) << 1) + (ACC_W'(r_win[2][1]) << 1)
               + (ACC_W'(r_win[1][1]) << 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= r_win_vld;
      if (r_win_vld) begin
        conv_out <= DATA_WIDTH'(w_sum >> 4);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_core.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_conv_core : table vectors plus scoreboard sequences for conv_core (5x5).
// Revision     : 1.0
//------------------------------------------------------------------------------
module tb_conv_core;

  localparam int DW = 8;
  localparam int IW = 5;
  localparam int IH = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic [DW-1:0] conv_out;
  logic          valid_out;

  conv_core #(
    .DATA_WIDTH (DW),
    .KERNEL_SIZE(3),
    .IMG_WIDTH  (IW),
    .IMG_HEIGHT (IH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pixel_in (pixel_in),
    .valid_in (valid_in),
    .conv_out (conv_out),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] val;
    int            cyc;
  } exp_t;

  typedef struct {
    logic [DW-1:0] win [3][3];
    logic [DW-1:0] exp;
  } vec_t;

  exp_t          sbq[$];
  vec_t          tbl[8];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            npulse = 0;
  logic [DW-1:0] mimg [IH][IW];
  int            mrow = 0;
  int            mcol = 0;
  bit            ovr_pend = 1'b0;
  logic [DW-1:0] ovr_val = '0;

  always @(posedge clk) cyc++;

  // Every pulse must match the oldest pending expectation in value and arrival cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && valid_out) begin
      npulse++;
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse conv_out=%0d cycle=%0d required=no pulse", conv_out, cyc);
      end else begin
        e = sbq.pop_front();
        if (conv_out !== e.val) begin
          failures++;
          $display("FAIL conv_value got=%0d required=%0d", conv_out, e.val);
        end
        checks++;
        if (cyc != e.cyc) begin
          failures++;
          $display("FAIL latency pulse_cycle=%0d required=%0d", cyc, e.cyc);
        end
      end
    end
  end

  function automatic logic [DW-1:0] kern(input int r, input int c);
    int s;
    int wt [3][3];
    wt = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
    s = 0;
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++)
        s += wt[dr][dc] * int'(mimg[r-2+dr][c-2+dc]);
    return DW'(s >> 4);
  endfunction

  task automatic drive(input logic [DW-1:0] p, input bit v);
    exp_t e;
    @(posedge clk); #1;
    pixel_in = p;
    valid_in = v;
    if (v) begin
      mimg[mrow][mcol] = p;
      if (mrow >= 2 && mcol >= 2) begin
        e.val = ovr_pend ? ovr_val : kern(mrow, mcol);
        e.cyc = cyc + 2;
        ovr_pend = 1'b0;
        sbq.push_back(e);
      end
      if (mcol == IW - 1) begin
        mcol = 0;
        mrow = (mrow == IH - 1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    drive('0, 1'b0);
    while (sbq.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d required=0", name, sbq.size());
      sbq.delete();
    end
  endtask

  task automatic check_pulses(input string name, input int start, input int req);
    checks++;
    if (npulse - start != req) begin
      failures++;
      $display("FAIL %s_pulse_count got=%0d required=%0d", name, npulse - start, req);
    end
  endtask

  task automatic do_reset(input int n, input bit chk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      pixel_in = DW'($urandom);
      valid_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (chk) begin
        checks += 2;
        if (conv_out !== '0) begin
          failures++;
          $display("FAIL reset_conv_out got=%0d required=0", conv_out);
        end
        if (valid_out !== 1'b0) begin
          failures++;
          $display("FAIL reset_valid_out got=%0b required=0", valid_out);
        end
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    rst_n    = 1'b1;
    mrow     = 0;
    mcol     = 0;
    ovr_pend = 1'b0;
    sbq.delete();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (valid_out !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_valid_out cycle=%0d got=%0b required=0", i, valid_out);
      end
    end
  endtask

  task automatic basic_stream(input bit gaps);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < IW; c++) begin
        drive(DW'(10 + 5 * r + 10 * c), 1'b1);
        if (gaps) idle($urandom_range(1, 4));
      end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int start;
    tbl[0].win = '{'{8'd10, 8'd20, 8'd30}, '{8'd15, 8'd25, 8'd35}, '{8'd20, 8'd30, 8'd40}};
    tbl[0].exp = 8'd25;
    tbl[1].win = '{'{8'd0, 8'd0, 8'd0}, '{8'd0, 8'd3, 8'd0}, '{8'd0, 8'd0, 8'd0}};
    tbl[1].exp = 8'd0;
    tbl[2].win = '{'{8'd255, 8'd255, 8'd255}, '{8'd255, 8'd255, 8'd255}, '{8'd255, 8'd255, 8'd255}};
    tbl[2].exp = 8'd255;
    tbl[3].win = '{'{8'd0, 8'd0, 8'd0}, '{8'd0, 8'd255, 8'd0}, '{8'd0, 8'd0, 8'd0}};
    tbl[3].exp = 8'd63;
    tbl[4].win = '{'{8'd16, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0}};
    tbl[4].exp = 8'd1;
    tbl[5].win = '{'{8'd15, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0}, '{8'd0, 8'd0, 8'd0}};
    tbl[5].exp = 8'd0;
    tbl[6].win = '{'{8'd0, 8'd8, 8'd0}, '{8'd8, 8'd0, 8'd8}, '{8'd0, 8'd8, 8'd0}};
    tbl[6].exp = 8'd4;
    tbl[7].win = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}, '{8'd7, 8'd8, 8'd9}};
    tbl[7].exp = 8'd5;

    do_reset(5, 1'b1);

    // Each vector is a 5x3 stream: window in columns 0-2, right column repeated in 3-4.
    for (int i = 0; i < 8; i++) begin
      start    = npulse;
      ovr_pend = 1'b1;
      ovr_val  = tbl[i].exp;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < IW; c++)
          drive(tbl[i].win[r][(c < 3) ? c : 2], 1'b1);
      drain($sformatf("vec%0d", i));
      check_pulses($sformatf("vec%0d", i), start, 3);
      do_reset(1, 1'b0);
    end

    start = npulse;
    basic_stream(1'b0);
    drain("basic");
    check_pulses("basic", start, 3);
    do_reset(1, 1'b0);

    start = npulse;
    basic_stream(1'b1);
    drain("gaps");
    check_pulses("gaps", start, 3);
    do_reset(1, 1'b0);

    start = npulse;
    for (int i = 0; i < IW * IH; i++) drive(8'd200, 1'b1);
    for (int i = 0; i < IW * IH; i++) drive(8'd0, 1'b1);
    drain("frames");
    check_pulses("frames", start, 18);

    do_reset(1, 1'b0);
    for (int i = 0; i < 8; i++) drive(8'd99, 1'b1);
    do_reset(2, 1'b0);
    start = npulse;
    basic_stream(1'b0);
    drain("midreset");
    check_pulses("midreset", start, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
